// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_t : receive sequencer states
//   FRAME_BITS : start + 8 data + parity + stop
//   START_IDX / PARITY_IDX / STOP_IDX : bit positions inside the captured frame
//   maj3()     : 2-of-3 majority vote used by the optional glitch filter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        DONE
    } rx_state_t;

    localparam int FRAME_BITS = 11;
    localparam int START_IDX  = 0;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line conditioning for the UART receiver.
// Optional feature macro: UART_RX_GLITCH_FILTER_EN (3-sample majority filter).
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   i_baud_tick  : oversample strobe (only present when the filter is built)
//   i_rx_in      : asynchronous serial input, idle high
//   o_rx_s       : synchronized line
//   o_rx_bit     : value used for bit decisions (majority when filtered,
//                  otherwise identical to o_rx_s)
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
`ifdef UART_RX_GLITCH_FILTER_EN
    input  logic i_baud_tick,
`endif
    input  logic i_rx_in,
    output logic o_rx_s,
    output logic o_rx_bit
);
`ifdef UART_RX_GLITCH_FILTER_EN
    import uart_pkg::*;
`endif

    logic r_meta;
    logic r_sync;

    // Flops reset high so the receiver sees an idle line out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rx_in;
            r_sync <= r_meta;
        end
    end

    assign o_rx_s = r_sync;

`ifdef UART_RX_GLITCH_FILTER_EN
    // r_hist holds the line at the two previous ticks; combined with the
    // current value, the vote is valid on the tick after the bit centre.
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (i_baud_tick) begin
            r_hist <= {r_hist[0], r_sync};
        end
    end

    assign o_rx_bit = maj3(r_hist[1], r_hist[0], r_sync);
`else
    assign o_rx_bit = r_sync;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: qualifies the start bit, samples the 11 frame bits
// at their centres and presents the frame with a one-clock received pulse.
// Optional feature macro: UART_RX_GLITCH_FILTER_EN (majority-voted sampling,
// every decision point one tick later).
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   i_baud_tick       : oversample strobe, OVERSAMPLE per bit period
//   i_rx_in           : asynchronous serial line, idle high
//   o_data_parll      : [0] start, [8:1] data LSB-first, [9] parity, [10] stop
//   o_recieved_flag   : one-clock pulse, frame and error flags valid
//   o_rx_active       : high whenever the sequencer is not idle
//   o_parity_err      : parity mismatch on last frame
//   o_framing_err     : stop bit sampled low on last frame
//
// state | meaning
// IDLE  | waiting for a low line on a baud tick
// START | counting to the start-bit centre, re-checking the line there
// DATA  | sampling one frame bit every OVERSAMPLE ticks, through the stop bit
// DONE  | single clock: frame presented, received pulse high
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_baud_tick,
    input  logic                  i_rx_in,
    output logic [FRAME_BITS-1:0] o_data_parll,
    output logic                  o_recieved_flag,
    output logic                  o_rx_active,
    output logic                  o_parity_err,
    output logic                  o_framing_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int SAMPLE_DLY = 1;
`else
    localparam int SAMPLE_DLY = 0;
`endif
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] START_EVAL = TICK_W'(OVERSAMPLE / 2 - 1 + SAMPLE_DLY);

    logic w_rx_s;
    logic w_rx_bit;

    uart_rx_sync u_sync (
        .clk         (clk),
        .rst         (rst),
`ifdef UART_RX_GLITCH_FILTER_EN
        .i_baud_tick (i_baud_tick),
`endif
        .i_rx_in     (i_rx_in),
        .o_rx_s      (w_rx_s),
        .o_rx_bit    (w_rx_bit)
    );

    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [TICK_W-1:0]     w_tick_nxt;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            w_bit_nxt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_shift_nxt;
    logic                  w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_baud_tick && !w_rx_s) begin
                    w_state_nxt = START;
                    w_tick_nxt  = '0;
                end
            end
            START: begin
                if (i_baud_tick) begin
                    if (r_tick_cnt == START_EVAL) begin
                        if (!w_rx_bit) begin
                            w_state_nxt            = DATA;
                            w_shift_nxt[START_IDX] = 1'b0;
                            w_tick_nxt             = '0;
                            w_bit_nxt              = 4'd1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_baud_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_shift_nxt[r_bit_cnt] = w_rx_bit;
                        w_tick_nxt             = '0;
                        w_bit_nxt              = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 4'(STOP_IDX)) begin
                            w_state_nxt = DONE;
                            w_load      = 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Results are captured on the stop-bit sampling edge so they are already
    // valid during the DONE clock when the received pulse is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data_parll  <= '0;
            o_parity_err  <= 1'b0;
            o_framing_err <= 1'b0;
        end else if (w_load) begin
            o_data_parll  <= w_shift_nxt;
            o_parity_err  <= (^w_shift_nxt[PARITY_IDX:START_IDX+1]) != 1'(PARITY_ODD);
            o_framing_err <= ~w_shift_nxt[STOP_IDX];
        end
    end

    assign o_recieved_flag = (r_state == DONE);
    assign o_rx_active     = (r_state != IDLE);

endmodule
